// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared widths, boot address, FSM encoding and trap cause codes for the next-PC sequencer
package pc_seq_pkg;
  localparam int CFG_XLEN = 32;
  localparam logic [CFG_XLEN-1:0] CFG_RESET_PC = 32'h8000_0000;
  localparam int CFG_ILEN_BYTES = 4;
  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_WAIT_RSP = 3'd1,
    S_EXEC     = 3'd2,
    S_COMMIT   = 3'd3,
    S_HALT     = 3'd4
  } state_t;
  localparam int CAUSE_INST_MISALIGNED   = 0;
  localparam int CAUSE_INST_ACCESS_FAULT = 1;
endpackage

// File: rtl/pc_seq_next_sel.sv
// pc_next_sel: priority mux for the next PC plus redirect-misalignment trap detection
//   i_pc            current PC
//   i_redirect/i_target  taken branch/jump and its target
//   i_trap/i_cause  execute-stage trap and its cause
//   i_mret          mret return
//   i_mtvec/i_mepc  trap vector base and mret return address
//   o_vec           word-aligned trap vector
//   o_next          selected next PC
//   o_trap/o_cause  trap request and its cause
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int XLEN       = CFG_XLEN,
  parameter int ILEN_BYTES = CFG_ILEN_BYTES
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_cause,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic [XLEN-1:0] o_vec,
  output logic [XLEN-1:0] o_next,
  output logic            o_trap,
  output logic [XLEN-1:0] o_cause
);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  logic w_mis;
  always_comb begin
    w_mis   = i_redirect & (i_target[1:0] != 2'b00);
    o_vec   = i_mtvec & ALIGN_MASK;
    o_next  = i_trap ? o_vec : i_mret ? i_mepc : w_mis ? o_vec :
              i_redirect ? i_target : i_pc + XLEN'(ILEN_BYTES);
    // mret outranks a misaligned redirect, so it suppresses that trap
    o_trap  = i_trap | (~i_mret & w_mis);
    o_cause = i_trap ? i_cause : XLEN'(CAUSE_INST_MISALIGNED);
  end
endmodule

// File: rtl/pc_seq.sv
// pc_seq: multi-cycle next-PC sequencer running fetch handshake, execute wait and one PC commit per instruction
//   clk/rst                 core clock, async active-high reset
//   pc_cur/pc_next/pc_w_en  PC register read value, next value and write pulse
//   if_req_*/if_addr        fetch request handshake and address
//   if_rsp_*                fetch response, access fault and data
//   inst/inst_valid         latched instruction and its one-cycle new pulse
//   exu_*                   execute completion, redirect, trap, mret and halt
//   csr_mtvec/csr_mepc      trap vector base and mret return address
//   trap_*                  CSR trap write pulse, faulting PC and cause
//   halted                  sticky halt
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int XLEN       = CFG_XLEN,
  parameter int ILEN_BYTES = CFG_ILEN_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_w_en,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] if_addr,
  input  logic            if_rsp_valid,
  input  logic            if_rsp_err,
  input  logic [XLEN-1:0] if_rsp_data,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  input  logic            exu_done,
  input  logic            exu_redirect,
  input  logic [XLEN-1:0] exu_target,
  input  logic            exu_trap,
  input  logic [XLEN-1:0] exu_cause,
  input  logic            exu_mret,
  input  logic            exu_halt,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_cause,
  output logic            halted
);
  state_t r_state, w_nxt;
  logic [XLEN-1:0] r_pc_next, r_inst, r_epc, r_cause;
  logic r_inst_valid, r_trap;
  logic [XLEN-1:0] w_vec, w_sel_next, w_sel_cause;
  logic w_sel_trap, w_rsp, w_done;
  pc_next_sel #(.XLEN(XLEN), .ILEN_BYTES(ILEN_BYTES)) u_sel (
    .i_pc       (pc_cur),
    .i_redirect (exu_redirect),
    .i_target   (exu_target),
    .i_trap     (exu_trap),
    .i_cause    (exu_cause),
    .i_mret     (exu_mret),
    .i_mtvec    (csr_mtvec),
    .i_mepc     (csr_mepc),
    .o_vec      (w_vec),
    .o_next     (w_sel_next),
    .o_trap     (w_sel_trap),
    .o_cause    (w_sel_cause)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_FETCH;
    else r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_FETCH:    w_nxt = if_req_ready ? S_WAIT_RSP : S_FETCH;
      S_WAIT_RSP: w_nxt = !if_rsp_valid ? S_WAIT_RSP : if_rsp_err ? S_COMMIT : S_EXEC;
      S_EXEC:     w_nxt = !exu_done ? S_EXEC : exu_halt ? S_HALT : S_COMMIT;
      S_COMMIT:   w_nxt = S_FETCH;
      S_HALT:     w_nxt = S_HALT;
      default:    w_nxt = S_FETCH;
    endcase
    w_rsp        = (r_state == S_WAIT_RSP) & if_rsp_valid;
    w_done       = (r_state == S_EXEC) & exu_done & ~exu_halt;
    if_req_valid = r_state == S_FETCH;
    if_addr      = pc_cur;
    pc_w_en      = r_state == S_COMMIT;
    halted       = r_state == S_HALT;
    // trap details are captured earlier but only reach the CSR unit alongside the commit
    trap_valid   = pc_w_en & r_trap;
    pc_next      = r_pc_next;
    inst         = r_inst;
    inst_valid   = r_inst_valid;
    trap_epc     = r_epc;
    trap_cause   = r_cause;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc_next    <= '0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_trap       <= 1'b0;
      r_epc        <= '0;
      r_cause      <= '0;
    end else begin
      r_inst_valid <= w_rsp & ~if_rsp_err;
      if (w_rsp & ~if_rsp_err) r_inst <= if_rsp_data;
      if (w_rsp & if_rsp_err) begin
        r_pc_next <= w_vec;
        r_trap    <= 1'b1;
        r_epc     <= pc_cur;
        r_cause   <= XLEN'(CAUSE_INST_ACCESS_FAULT);
      end else if (w_done) begin
        r_pc_next <= w_sel_next;
        r_trap    <= w_sel_trap;
        r_epc     <= pc_cur;
        r_cause   <= w_sel_cause;
      end
    end
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: scoreboard bench for pc_seq with PC register, memory and execute-stage models
module tb_pc_seq;
  import pc_seq_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] pc_cur, pc_next, if_addr, if_rsp_data, inst, exu_target, exu_cause;
  logic [31:0] csr_mtvec, csr_mepc, trap_epc, trap_cause, acc_addr, err_addr;
  logic pc_w_en, if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err, inst_valid;
  logic exu_done, exu_redirect, exu_trap, exu_mret, exu_halt, trap_valid, halted, acc;
  int errors = 0, checks = 0, commits = 0, ivs = 0, cyc = 0, last_commit = 0, stall = 0;
  int t1, n, quiet;
  typedef struct {
    logic [31:0] nx;
    logic        tv;
    logic [31:0] epc;
    logic [31:0] cause;
  } exp_t;
  exp_t q[$];
  exp_t e;

  pc_seq dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .pc_w_en(pc_w_en),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_err(if_rsp_err), .if_rsp_data(if_rsp_data),
    .inst(inst), .inst_valid(inst_valid), .exu_done(exu_done), .exu_redirect(exu_redirect),
    .exu_target(exu_target), .exu_trap(exu_trap), .exu_cause(exu_cause), .exu_mret(exu_mret),
    .exu_halt(exu_halt), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .trap_valid(trap_valid),
    .trap_epc(trap_epc), .trap_cause(trap_cause), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endtask

  task automatic push(input logic [31:0] nx, input logic tv, input logic [31:0] epc, input logic [31:0] cause);
    exp_t t;
    t.nx = nx; t.tv = tv; t.epc = epc; t.cause = cause;
    q.push_back(t);
  endtask

  task automatic wait_commit();
    int s = commits;
    int k = 0;
    while (commits == s && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (commits == s) begin
      checks++;
      errors++;
      $display("FAIL commit_timeout: got no pc_w_en in 60 cycles, expected one");
    end
  endtask

  // PC register and fetch acceptance, sampled on the active edge
  initial forever begin
    @(posedge clk);
    cyc++;
    if (pc_w_en) pc_cur = pc_next;
  end
  initial forever begin
    @(posedge clk or posedge rst);
    acc = rst ? 1'b0 : (if_req_valid & if_req_ready);
    acc_addr = if_addr;
  end
  // memory answers one cycle after acceptance; execute finishes in the cycle inst_valid shows
  initial forever begin
    @(negedge clk);
    if_rsp_valid = acc;
    if_rsp_err = acc && (acc_addr == err_addr);
    if_rsp_data = {acc_addr[15:0], 16'h0013};
    if (stall > 0 && if_req_valid) begin
      if_req_ready = 1'b0;
      stall--;
    end else if_req_ready = 1'b1;
    exu_done = inst_valid;
  end

  always @(negedge clk) if (!rst) begin
    chk("trap_outside_commit", {31'd0, trap_valid & ~pc_w_en}, 32'd0);
    if (inst_valid) begin
      ivs++;
      chk("inst", inst, {pc_cur[15:0], 16'h0013});
    end
    if (pc_w_en) begin
      commits++;
      last_commit = cyc;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got pc_next %h, expected no commit", pc_next);
      end else begin
        e = q.pop_front();
        chk("pc_next", pc_next, e.nx);
        chk("trap_valid", {31'd0, trap_valid}, {31'd0, e.tv});
        if (e.tv) begin
          chk("trap_epc", trap_epc, e.epc);
          chk("trap_cause", trap_cause, e.cause);
        end
      end
    end
  end

  initial begin
    pc_cur = CFG_RESET_PC; err_addr = 32'hFFFF_FFFF;
    exu_redirect = 0; exu_trap = 0; exu_mret = 0; exu_halt = 0;
    exu_target = 0; exu_cause = 0; exu_done = 0;
    csr_mtvec = 32'h8000_0201; csr_mepc = 32'h8000_0010;
    if_req_ready = 1; if_rsp_valid = 0; if_rsp_err = 0; if_rsp_data = 0; acc = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_w_en", {31'd0, pc_w_en}, 0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 0);
    chk("rst_trap_valid", {31'd0, trap_valid}, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc_next", pc_next, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_req_valid", {31'd0, if_req_valid}, 1);
    @(negedge clk);
    rst = 0;
    #1;
    chk("boot_addr", if_addr, 32'h8000_0000);
    push(32'h8000_0004, 0, 0, 0);
    wait_commit();
    t1 = last_commit;
    push(32'h8000_0008, 0, 0, 0);
    wait_commit();
    chk("cycles_per_inst", last_commit - t1, 4);
    stall = 3;
    push(32'h8000_000C, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("stall_req_valid", {31'd0, if_req_valid}, 1);
      chk("stall_addr", if_addr, 32'h8000_0008);
      chk("stall_no_inst", {31'd0, inst_valid}, 0);
    end
    wait_commit();
    exu_redirect = 1; exu_target = 32'h8000_0100;
    push(32'h8000_0100, 0, 0, 0);
    wait_commit();
    exu_target = 32'h8000_0102;
    push(32'h8000_0200, 1, 32'h8000_0100, 0);
    wait_commit();
    exu_redirect = 0; exu_trap = 1; exu_mret = 1; exu_cause = 11;
    push(32'h8000_0200, 1, 32'h8000_0200, 11);
    wait_commit();
    exu_trap = 0;
    push(32'h8000_0010, 0, 0, 0);
    wait_commit();
    exu_mret = 0;
    err_addr = 32'h8000_0010;
    n = ivs;
    push(32'h8000_0200, 1, 32'h8000_0010, 1);
    wait_commit();
    chk("no_inst_on_fault", ivs, n);
    err_addr = 32'hFFFF_FFFF;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("in_wait_rsp", {31'd0, if_req_valid}, 0);
    rst = 1;
    #1;
    chk("mid_rst_req_valid", {31'd0, if_req_valid}, 1);
    chk("mid_rst_pc_next", pc_next, 0);
    chk("mid_rst_inst", inst, 0);
    chk("mid_rst_pulses", {29'd0, pc_w_en, inst_valid, trap_valid}, 0);
    pc_cur = 32'hFFFF_FFFC;
    repeat (2) @(negedge clk);
    #1;
    rst = 0;
    push(32'h0000_0000, 0, 0, 0);
    wait_commit();
    exu_halt = 1;
    for (int i = 0; i < 20 && !halted; i++) begin
      @(negedge clk);
      #1;
    end
    chk("halted", {31'd0, halted}, 1);
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (if_req_valid | pc_w_en | trap_valid | inst_valid | ~halted) quiet++;
    end
    chk("halt_quiet", quiet, 0);
    rst = 1; exu_halt = 0; pc_cur = CFG_RESET_PC;
    #1;
    chk("halt_cleared", {31'd0, halted}, 0);
    repeat (2) @(negedge clk);
    #1;
    rst = 0;
    push(32'h8000_0004, 0, 0, 0);
    wait_commit();
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Multi-cycle next-PC sequencer for the NPC core.
- Drives the write-enable and next value of the PC register, and runs the instruction-fetch handshake with the instruction memory port.
- Receives completion, redirect and trap information from the execute stage.
- Picks the next PC (sequential, branch/jump target, trap vector, mret return) and commits it exactly once per instruction.

Parameters:
- XLEN, 32, PC / address / instruction width; equals the core ISA width.
- RESET_PC, 32'h8000_0000, PC base address; used only for the boot fetch address check.
- ILEN_BYTES, 4, sequential increment; no compressed instructions.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- pc_cur  in  XLEN  current PC register output
- pc_next  out  XLEN  next PC value to the PC register
- pc_w_en  out  1  PC register write enable, one-cycle pulse
- if_req_valid  out  1  fetch request valid
- if_req_ready  in  1  memory accepts request
- if_addr  out  XLEN  fetch address (= pc_cur)
- if_rsp_valid  in  1  fetch data valid
- if_rsp_err  in  1  fetch access fault, qualified by if_rsp_valid
- if_rsp_data  in  XLEN  fetched instruction
- inst  out  XLEN  latched instruction to decoder
- inst_valid  out  1  one-cycle pulse: inst is new
- exu_done  in  1  execute stage finished the current instruction
- exu_redirect  in  1  taken branch/jump, qualified by exu_done
- exu_target  in  XLEN  redirect target
- exu_trap  in  1  ecall/illegal instruction, qualified by exu_done
- exu_cause  in  XLEN  cause for exu_trap
- exu_mret  in  1  mret, qualified by exu_done
- exu_halt  in  1  ebreak, qualified by exu_done
- csr_mtvec  in  XLEN  trap vector base (direct mode)
- csr_mepc  in  XLEN  mret return address
- trap_valid  out  1  one-cycle pulse: CSR unit writes mepc/mcause
- trap_epc  out  XLEN  faulting PC
- trap_cause  out  XLEN  mcause value
- halted  out  1  sticky halt indication

Behaviour:
- States: FETCH, WAIT_RSP, EXEC, COMMIT, HALT. Reset state is FETCH.
- Reset (async, any state): FETCH; all pulses 0; inst = 0; pc_next = 0; halted = 0. Any outstanding fetch is abandoned; the memory side must also be reset.
- FETCH:
  - if_req_valid = 1, if_addr = pc_cur.
  - On if_req_ready: go to WAIT_RSP. Same-cycle ready gives a 1-cycle request.
  - if_req_valid stays asserted until accepted; if_addr is stable meanwhile.
- WAIT_RSP, on if_rsp_valid:
  - If if_rsp_err: trap with cause 1, epc = pc_cur; go to COMMIT.
  - Else: latch inst = if_rsp_data, pulse inst_valid for 1 cycle, go to EXEC.
  - A response arriving in the same cycle as acceptance is not allowed; the memory latency is at least 1.
- EXEC: wait for exu_done. When it arrives, compute pc_next with this priority:
  1. exu_halt: go to HALT; no commit.
  2. exu_trap: pc_next = {csr_mtvec[XLEN-1:2], 2'b00}; trap_valid, trap_epc = pc_cur, trap_cause = exu_cause.
  3. exu_mret: pc_next = csr_mepc.
  4. exu_redirect with exu_target[1:0] != 0: trap with cause 0, epc = pc_cur, pc_next = mtvec.
  5. exu_redirect: pc_next = exu_target.
  6. Otherwise: pc_next = pc_cur + ILEN_BYTES, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
  - Then go to COMMIT.
- COMMIT:
  - pc_w_en = 1 for exactly 1 cycle; pc_next is registered and stable through this cycle.
  - Next state is FETCH, so the new pc_cur is visible when the next fetch starts.
- trap_valid pulses in the same cycle as pc_w_en (COMMIT), never in EXEC.
- HALT: absorbing; halted = 1; no requests, no pulses. Only rst leaves it.
- exu_done outside EXEC, and if_rsp_valid outside WAIT_RSP, are ignored.
- Latency without stalls: FETCH 1 + WAIT_RSP ≥1 + EXEC ≥1 + COMMIT 1, i.e. minimum 4 cycles per instruction.

Decomposition:
- Shared config package holds:
  - ISA width and PC base address constants;
  - state encoding constants (3-bit);
  - cause codes: INST_MISALIGNED = 0, INST_ACCESS_FAULT = 1.
- One natural sub-module: pc_next_sel, the combinational priority mux plus misalignment check. The FSM and registers stay in pc_seq.

Test Plan:
- Reset with pc_cur = 0x8000_0000, ready = 1, response 1 cycle later with data 0x0000_0013, exu_done 1 cycle after inst_valid -> if_addr = 0x8000_0000; inst = 0x13; pc_w_en pulses once with pc_next = 0x8000_0004; 4 cycles per instruction.
- Hold if_req_ready = 0 for 3 cycles -> if_req_valid and if_addr held constant; no inst_valid; accepted in cycle 4.
- exu_redirect = 1 with exu_target = 0x8000_0100 -> pc_next = 0x8000_0100; exu_target = 0x8000_0102 -> trap_valid, trap_cause = 0, trap_epc = pc_cur, pc_next = mtvec & ~3.
- exu_trap and exu_mret both set, exu_cause = 11, csr_mtvec = 0x8000_0201 -> trap wins; pc_next = 0x8000_0200; trap_cause = 11.
- if_rsp_err on fetch at 0x8000_0010 -> no inst_valid; trap_cause = 1, trap_epc = 0x8000_0010; commit to mtvec. Separately, pc_cur = 0xFFFF_FFFC sequential -> pc_next = 0.
- exu_halt -> halted = 1, no further requests for 20 cycles; rst asserted in WAIT_RSP -> immediate FETCH, all outputs at reset values.
